// File: rtl/dac_chain_pkg.sv
// Shared constants, width helpers and command decoding for the DAC daisy-chain controller.
// The command enum captures the {transfer, dir, shift} pin combinations after priority resolution.
package dac_chain_pkg;

    localparam int DEF_WIDTH = 128;
    localparam int DEF_LANES = 1;
    localparam int DEF_NBANK = 2;
    localparam int DEF_TAP_W = 8;

    typedef enum logic [2:0] {
        CMD_IDLE     = 3'b000,
        CMD_SHIFT    = 3'b001,
        CMD_READBACK = 3'b100,
        CMD_COMMIT   = 3'b110
    } cmd_e;

    function automatic int calc_bsw(input int nbank);
        int bsw;
        if (nbank <= 1) begin
            bsw = 1;
        end else begin
            bsw = $clog2(nbank);
        end
        return bsw;
    endfunction

    function automatic int calc_cw(input int width, input int lanes);
        return $clog2(width / lanes) + 1;
    endfunction

    // Transfer outranks shift, so a shift pulse coincident with a transfer is discarded here.
    function automatic cmd_e decode_cmd(input logic transfer, input logic dir, input logic shift);
        cmd_e cmd;
        if (transfer && dir) begin
            cmd = CMD_COMMIT;
        end else if (transfer) begin
            cmd = CMD_READBACK;
        end else if (shift) begin
            cmd = CMD_SHIFT;
        end else begin
            cmd = CMD_IDLE;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/dac_bank_regfile.sv
// NBANK x WIDTH shadow state banks: one guarded write port and two independent read ports.
// Addresses at or beyond NBANK match no bank, so writes drop and reads return zero with valid low.
module dac_bank_regfile
    import dac_chain_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NBANK = DEF_NBANK,
    parameter int BSW   = calc_bsw(DEF_NBANK)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [BSW-1:0]   waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [BSW-1:0]   raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    output logic             rvalid_a,
    input  logic [BSW-1:0]   raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic             rvalid_b
);

    logic [WIDTH-1:0] bank_r [NBANK];

    // Bank storage with synchronous clear and address-matched write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NBANK; i++) begin
                bank_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NBANK; i++) begin
                if (we && (waddr == BSW'(i))) begin
                    bank_r[i] <= wdata;
                end else begin
                    bank_r[i] <= bank_r[i];
                end
            end
        end
    end

    // Read port A: transfer readback source.
    always_comb begin
        rdata_a  = '0;
        rvalid_a = 1'b0;
        for (int i = 0; i < NBANK; i++) begin
            if (raddr_a == BSW'(i)) begin
                rdata_a  = bank_r[i];
                rvalid_a = 1'b1;
            end else begin
                rdata_a  = rdata_a;
                rvalid_a = rvalid_a;
            end
        end
    end

    // Read port B: bank feeding the DAC output register.
    always_comb begin
        rdata_b  = '0;
        rvalid_b = 1'b0;
        for (int i = 0; i < NBANK; i++) begin
            if (raddr_b == BSW'(i)) begin
                rdata_b  = bank_r[i];
                rvalid_b = 1'b1;
            end else begin
                rdata_b  = rdata_b;
                rvalid_b = rvalid_b;
            end
        end
    end

endmodule

// File: rtl/dac_chain_ctrl.sv
// Multi-lane daisy-chain loader with NBANK shadow state banks and a registered DAC switch stage.
// Frames are BEATS = WIDTH/LANES shifts long; a completed frame may auto-commit into bank_sel.
module dac_chain_ctrl
    import dac_chain_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES,
    parameter int NBANK = DEF_NBANK,
    parameter int TAP_W = DEF_TAP_W,
    localparam int BSW  = calc_bsw(NBANK),
    localparam int CW   = calc_cw(WIDTH, LANES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LANES-1:0] datum,
    input  logic             shift,
    input  logic             transfer,
    input  logic             dir,
    input  logic             auto_en,
    input  logic [BSW-1:0]   bank_sel,
    input  logic [BSW-1:0]   active_sel,
    output logic [WIDTH-1:0] dac_on,
    output logic [WIDTH-1:0] dac_onb,
    output logic [TAP_W-1:0] chain_tap,
    output logic [TAP_W-1:0] state_tap,
    output logic [CW-1:0]    beat_cnt,
    output logic             frame_done
);

    localparam int BEATS = WIDTH / LANES;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    if ((WIDTH % LANES) != 0) begin : g_chk_width
        $error("dac_chain_ctrl: WIDTH must be a multiple of LANES");
    end
    if (!((LANES == 1) || (LANES == 2) || (LANES == 4) || (LANES == 8))) begin : g_chk_lanes
        $error("dac_chain_ctrl: LANES must be 1, 2, 4 or 8");
    end
    if (TAP_W > WIDTH) begin : g_chk_tap
        $error("dac_chain_ctrl: TAP_W must not exceed WIDTH");
    end
    if ((NBANK < 1) || (NBANK > 8)) begin : g_chk_nbank
        $error("dac_chain_ctrl: NBANK must be in 1..8");
    end

    logic [WIDTH-1:0] chain_r;
    logic [CW-1:0]    beat_cnt_r;
    logic             frame_done_r;
    logic [WIDTH-1:0] dac_on_r;

    cmd_e             cmd_s;
    logic [WIDTH-1:0] shifted_s;
    logic [WIDTH-1:0] chain_nxt_s;
    logic [CW-1:0]    cnt_nxt_s;
    logic             done_nxt_s;
    logic             bank_we_s;
    logic [WIDTH-1:0] bank_wdata_s;
    logic [WIDTH-1:0] rb_data_s;
    logic             rb_valid_s;
    logic [WIDTH-1:0] act_data_s;
    logic             act_valid_s;

    assign cmd_s     = decode_cmd(transfer, dir, shift);
    assign shifted_s = (chain_r << LANES) | WIDTH'(datum);

    dac_bank_regfile #(
        .WIDTH (WIDTH),
        .NBANK (NBANK),
        .BSW   (BSW)
    ) u_banks (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (bank_we_s),
        .waddr    (bank_sel),
        .wdata    (bank_wdata_s),
        .raddr_a  (bank_sel),
        .rdata_a  (rb_data_s),
        .rvalid_a (rb_valid_s),
        .raddr_b  (active_sel),
        .rdata_b  (act_data_s),
        .rvalid_b (act_valid_s)
    );

    // Next-state decode for chain, frame counter and bank write port.
    always_comb begin
        chain_nxt_s  = chain_r;
        cnt_nxt_s    = beat_cnt_r;
        done_nxt_s   = 1'b0;
        bank_we_s    = 1'b0;
        bank_wdata_s = chain_r;
        case (cmd_s)
            CMD_SHIFT: begin
                chain_nxt_s = shifted_s;
                if (beat_cnt_r == LAST_BEAT) begin
                    cnt_nxt_s    = {CW{1'b0}};
                    done_nxt_s   = 1'b1;
                    // Auto-commit takes the post-shift chain so the bank matches the full frame.
                    bank_we_s    = auto_en;
                    bank_wdata_s = shifted_s;
                end else begin
                    cnt_nxt_s = beat_cnt_r + CW'(1);
                end
            end
            CMD_COMMIT: begin
                bank_we_s    = 1'b1;
                bank_wdata_s = chain_r;
            end
            CMD_READBACK: begin
                chain_nxt_s = rb_valid_s ? rb_data_s : {WIDTH{1'b0}};
                cnt_nxt_s   = {CW{1'b0}};
            end
            CMD_IDLE: begin
                chain_nxt_s = chain_r;
            end
            default: begin
                chain_nxt_s = chain_r;
            end
        endcase
    end

    // Chain, framing and DAC output registers; an unaddressable active_sel freezes dac_on.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain_r      <= '0;
            beat_cnt_r   <= '0;
            frame_done_r <= 1'b0;
            dac_on_r     <= '0;
        end else begin
            chain_r      <= chain_nxt_s;
            beat_cnt_r   <= cnt_nxt_s;
            frame_done_r <= done_nxt_s;
            dac_on_r     <= act_valid_s ? act_data_s : dac_on_r;
        end
    end

    assign dac_on     = dac_on_r;
    assign dac_onb    = ~dac_on_r;
    assign chain_tap  = chain_r[WIDTH-1 -: TAP_W];
    assign state_tap  = dac_on_r[WIDTH-1 -: TAP_W];
    assign beat_cnt   = beat_cnt_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_dac_chain_ctrl.sv
// Scoreboard bench for dac_chain_ctrl (WIDTH=128, LANES=4, NBANK=3): a bit-queue reference model
// pushes the expected post-edge outputs; a negedge monitor pops and compares them.
module tb_dac_chain_ctrl;
    import dac_chain_pkg::*;

    localparam int WIDTH = 128;
    localparam int LANES = 4;
    localparam int NBANK = 3;
    localparam int TAP_W = 8;
    localparam int BSW   = calc_bsw(NBANK);
    localparam int CW    = calc_cw(WIDTH, LANES);
    localparam int BEATS = WIDTH / LANES;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [LANES-1:0] datum;
    logic             shift;
    logic             transfer;
    logic             dir;
    logic             auto_en;
    logic [BSW-1:0]   bank_sel;
    logic [BSW-1:0]   active_sel;
    logic [WIDTH-1:0] dac_on;
    logic [WIDTH-1:0] dac_onb;
    logic [TAP_W-1:0] chain_tap;
    logic [TAP_W-1:0] state_tap;
    logic [CW-1:0]    beat_cnt;
    logic             frame_done;

    dac_chain_ctrl #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .NBANK (NBANK),
        .TAP_W (TAP_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .datum      (datum),
        .shift      (shift),
        .transfer   (transfer),
        .dir        (dir),
        .auto_en    (auto_en),
        .bank_sel   (bank_sel),
        .active_sel (active_sel),
        .dac_on     (dac_on),
        .dac_onb    (dac_onb),
        .chain_tap  (chain_tap),
        .state_tap  (state_tap),
        .beat_cnt   (beat_cnt),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] dac_on;
        logic [TAP_W-1:0] chain_tap;
        int               beat_cnt;
        logic             frame_done;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model: chain as a queue of bits, oldest (MSB) at the front.
    bit               m_chain[$];
    logic [WIDTH-1:0] m_bank[NBANK];
    logic [WIDTH-1:0] m_dac;
    int               m_beats;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end else begin
            passed++;
        end
    endtask

    function automatic logic [WIDTH-1:0] chain_vec();
        logic [WIDTH-1:0] v;
        for (int i = 0; i < WIDTH; i++) v[WIDTH-1-i] = m_chain[i];
        return v;
    endfunction

    task automatic load_chain(input logic [WIDTH-1:0] v);
        m_chain = {};
        for (int i = WIDTH - 1; i >= 0; i--) m_chain.push_back(v[i]);
    endtask

    task automatic model_edge();
        logic [WIDTH-1:0] old_chain;
        logic [WIDTH-1:0] cv;
        exp_t             e;
        bit               done;
        int               bs;
        int               as;
        old_chain = chain_vec();
        done = 1'b0;
        bs = int'(bank_sel);
        as = int'(active_sel);
        if (!rst_n) begin
            load_chain('0);
            for (int b = 0; b < NBANK; b++) m_bank[b] = '0;
            m_dac = '0;
            m_beats = 0;
        end else begin
            if (as < NBANK) m_dac = m_bank[as];
            if (transfer) begin
                if (dir) begin
                    if (bs < NBANK) m_bank[bs] = old_chain;
                end else begin
                    load_chain((bs < NBANK) ? m_bank[bs] : '0);
                    m_beats = 0;
                end
            end else if (shift) begin
                for (int l = LANES - 1; l >= 0; l--) begin
                    void'(m_chain.pop_front());
                    m_chain.push_back(datum[l]);
                end
                m_beats++;
                if (m_beats == BEATS) begin
                    m_beats = 0;
                    done = 1'b1;
                    if (auto_en && (bs < NBANK)) m_bank[bs] = chain_vec();
                end
            end
        end
        cv = chain_vec();
        e.dac_on = m_dac;
        e.chain_tap = cv[WIDTH-1 -: TAP_W];
        e.beat_cnt = m_beats;
        e.frame_done = done;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic sh, input logic tr, input logic d, input logic [LANES-1:0] dt);
        shift = sh;
        transfer = tr;
        dir = d;
        datum = dt;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Monitor: every edge produces one expected record, compared away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("dac_on", dac_on, mon_e.dac_on);
            check("dac_onb", dac_onb, ~mon_e.dac_on);
            check("state_tap", WIDTH'(state_tap), WIDTH'(mon_e.dac_on[WIDTH-1 -: TAP_W]));
            check("chain_tap", WIDTH'(chain_tap), WIDTH'(mon_e.chain_tap));
            check("beat_cnt", WIDTH'(beat_cnt), WIDTH'(mon_e.beat_cnt));
            check("frame_done", WIDTH'(frame_done), WIDTH'(mon_e.frame_done));
        end
    end

    initial begin
        rst_n = 1'b0;
        shift = 1'b0;
        transfer = 1'b0;
        dir = 1'b0;
        auto_en = 1'b0;
        datum = '0;
        bank_sel = '0;
        active_sel = '0;
        m_dac = '0;
        m_beats = 0;
        load_chain('0);
        for (int b = 0; b < NBANK; b++) m_bank[b] = '0;

        repeat (2) cyc(1'b0, 1'b0, 1'b0, 4'h0);
        rst_n = 1'b1;

        // 0xA5 pattern frame with auto-commit into bank0 driving the output.
        auto_en = 1'b1;
        bank_sel = 2'd0;
        active_sel = 2'd0;
        for (int i = 0; i < BEATS; i++) cyc(1'b1, 1'b0, 1'b0, (i % 2 == 0) ? 4'hA : 4'h5);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 4'h0);

        // Two back-to-back frames of 4'hC under continuous shift.
        auto_en = 1'b0;
        for (int i = 0; i < 2 * BEATS; i++) cyc(1'b1, 1'b0, 1'b0, 4'hC);
        cyc(1'b0, 1'b0, 1'b0, 4'h0);

        // Commit 0x0F.. into bank1, disturb the chain, then read bank1 back.
        for (int i = 0; i < BEATS; i++) cyc(1'b1, 1'b0, 1'b0, (i % 2 == 0) ? 4'h0 : 4'hF);
        bank_sel = 2'd1;
        cyc(1'b0, 1'b1, 1'b1, 4'h0);
        active_sel = 2'd1;
        repeat (5) cyc(1'b1, 1'b0, 1'b0, LANES'($urandom));
        cyc(1'b0, 1'b1, 1'b0, 4'h0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 4'h0);

        // Transfer and shift on the same edge: transfer wins.
        repeat (7) cyc(1'b1, 1'b0, 1'b0, LANES'($urandom));
        cyc(1'b1, 1'b1, 1'b1, LANES'($urandom));
        cyc(1'b0, 1'b0, 1'b0, 4'h0);

        // Reset mid-frame, then a full frame is needed for frame_done.
        repeat (12) cyc(1'b1, 1'b0, 1'b0, 4'hF);
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 4'h0);
        rst_n = 1'b1;
        for (int i = 0; i < BEATS + 2; i++) cyc(1'b1, 1'b0, 1'b0, LANES'($urandom));

        // Out-of-range bank selects on the three-bank configuration.
        bank_sel = 2'd2;
        cyc(1'b0, 1'b1, 1'b1, 4'h0);
        for (int i = 0; i < BEATS; i++) cyc(1'b1, 1'b0, 1'b0, LANES'($urandom));
        bank_sel = 2'd3;
        cyc(1'b0, 1'b1, 1'b1, 4'h0);
        active_sel = 2'd0;
        cyc(1'b0, 1'b0, 1'b0, 4'h0);
        active_sel = 2'd3;
        bank_sel = 2'd0;
        cyc(1'b0, 1'b1, 1'b1, 4'h0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 4'h0);
        bank_sel = 2'd3;
        cyc(1'b0, 1'b1, 1'b0, 4'h0);
        active_sel = 2'd2;
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 4'h0);

        // Randomised traffic, shift-heavy so frames still complete.
        for (int n = 0; n < 1500; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            auto_en = 1'($urandom);
            bank_sel = BSW'($urandom);
            active_sel = BSW'($urandom);
            cyc($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, 1'($urandom), LANES'($urandom));
        end
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 4'h0);

        @(negedge clk);
        #1;
        check("scoreboard_drain", WIDTH'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
